// File: rtl/axis_wtow2.sv
// axis_wtow2 -- AXI4-Stream width up-converter.
//
// Packs pairs of C_WIDTH_TDATA/2-bit input beats into one C_WIDTH_TDATA-bit
// output beat. The first narrow beat of a pair lands in the low lanes and the
// second in the high lanes. A packet that ends on an odd beat is emitted as a
// half beat with zero upper data and keep, so two packets never share a wide
// beat. One narrow beat per cycle is sustained while out_TREADY stays high.
//
// Ports:
//   clk_line        line clock, rising edge
//   clk_line_rst_n  asynchronous active-low reset
//   in_TVALID/in_TREADY/in_TDATA/in_TKEEP/in_TLAST      narrow AXIS slave
//   out_TVALID/out_TREADY/out_TDATA/out_TKEEP/out_TLAST wide AXIS master,
//                                                       all outputs registered
module axis_wtow2 #(
  parameter int C_WIDTH_TDATA = 512,
  parameter int C_WIDTH_TKEEP = C_WIDTH_TDATA / 8
) (
  input  logic                       clk_line,
  input  logic                       clk_line_rst_n,
  input  logic                       in_TVALID,
  output logic                       in_TREADY,
  input  logic [C_WIDTH_TDATA/2-1:0] in_TDATA,
  input  logic [C_WIDTH_TKEEP/2-1:0] in_TKEEP,
  input  logic                       in_TLAST,
  output logic                       out_TVALID,
  input  logic                       out_TREADY,
  output logic [C_WIDTH_TDATA-1:0]   out_TDATA,
  output logic [C_WIDTH_TKEEP-1:0]   out_TKEEP,
  output logic                       out_TLAST
);

  localparam int HW = C_WIDTH_TDATA / 2;
  localparam int HK = C_WIDTH_TKEEP / 2;

  // S_LOW : nothing held, no wide beat pending
  // S_HIGH: low half held, waiting for its partner
  // S_FULL: wide beat presented on the output
  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_HIGH = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t        state;
  logic [HW-1:0] held_low;
  logic [HK-1:0] held_keep;

  logic accept;
  logic emit;
  logic first_slot;

  // Ready depends only on state and downstream ready, never on in_TVALID.
  assign in_TREADY = clk_line_rst_n && ((state != S_FULL) || out_TREADY);
  assign accept    = in_TVALID && in_TREADY;
  assign emit      = out_TVALID && out_TREADY;

  // A new beat starts a pair either from idle or when the pending wide beat
  // leaves in the same cycle (back-to-back operation out of S_FULL).
  assign first_slot = (state == S_LOW) || ((state == S_FULL) && emit);

  // NOTE: every register here, datapath included, is cleared by reset so the
  // output bus reads zero and no stale half beat survives a mid-packet reset.
  always_ff @(posedge clk_line or negedge clk_line_rst_n) begin
    if (!clk_line_rst_n) begin
      state      <= S_LOW;
      held_low   <= '0;
      held_keep  <= '0;
      out_TVALID <= 1'b0;
      out_TLAST  <= 1'b0;
      out_TDATA  <= '0;
      out_TKEEP  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge state and the order of statements below does not matter.
      if (first_slot) begin
        if (accept && in_TLAST) begin
          // Single-beat tail: emit a half beat with empty upper lanes.
          out_TDATA  <= {{HW{1'b0}}, in_TDATA};
          out_TKEEP  <= {{HK{1'b0}}, in_TKEEP};
          out_TLAST  <= 1'b1;
          out_TVALID <= 1'b1;
          state      <= S_FULL;
        end else if (accept) begin
          held_low   <= in_TDATA;
          held_keep  <= in_TKEEP;
          out_TVALID <= 1'b0;
          state      <= S_HIGH;
        end else if (state == S_FULL) begin
          // Pending beat taken, nothing new arrived.
          out_TVALID <= 1'b0;
          state      <= S_LOW;
        end
      end else if ((state == S_HIGH) && accept) begin
        out_TDATA  <= {in_TDATA, held_low};
        out_TKEEP  <= {in_TKEEP, held_keep};
        out_TLAST  <= in_TLAST;
        out_TVALID <= 1'b1;
        state      <= S_FULL;
      end
      // S_FULL without emit: output held stable under backpressure.
    end
  end

endmodule

// File: tb/tb_axis_wtow2.sv
module tb_axis_wtow2;

  localparam int W  = 512;
  localparam int K  = W / 8;
  localparam int HW = W / 2;
  localparam int HK = K / 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [HW-1:0] in_data;
  logic [HK-1:0] in_keep;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [K-1:0]  out_keep;
  logic          out_last;

  int tests = 0;
  int fails = 0;

  axis_wtow2 #(.C_WIDTH_TDATA(W), .C_WIDTH_TKEEP(K)) dut (
    .clk_line       (clk),
    .clk_line_rst_n (rst_n),
    .in_TVALID      (in_valid),
    .in_TREADY      (in_ready),
    .in_TDATA       (in_data),
    .in_TKEEP       (in_keep),
    .in_TLAST       (in_last),
    .out_TVALID     (out_valid),
    .out_TREADY     (out_ready),
    .out_TDATA      (out_data),
    .out_TKEEP      (out_keep),
    .out_TLAST      (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [HW-1:0] rnd_half();
    logic [HW-1:0] r;
    for (int i = 0; i < HW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  // Accepted narrow beats of the current packet are collected; whenever two
  // have gathered, or the packet ends, they form one expected wide beat with
  // beat i occupying lanes [i*HW +: HW] and everything unused left zero.
  typedef struct {
    logic [W-1:0] data;
    logic [K-1:0] keep;
    logic         last;
  } wide_t;

  wide_t         exp_q[$];
  logic [HW-1:0] pend_d[$];
  logic [HK-1:0] pend_k[$];

  logic         stalled;
  logic [W-1:0] sv_data;
  logic [K-1:0] sv_keep;
  logic         sv_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      pend_d.delete();
      pend_k.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_data", out_data, sv_data);
        check("stall_keep", {{(W-K){1'b0}}, out_keep}, {{(W-K){1'b0}}, sv_keep});
        check("stall_last", {{(W-1){1'b0}}, out_last}, {{(W-1){1'b0}}, sv_last});
      end
      stalled = out_valid && !out_ready;
      sv_data = out_data;
      sv_keep = out_keep;
      sv_last = out_last;

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("emit_unexpected", {{(W-1){1'b0}}, out_valid}, '0);
        end else begin
          wide_t e;
          e = exp_q.pop_front();
          check("emit_data", out_data, e.data);
          check("emit_keep", {{(W-K){1'b0}}, out_keep}, {{(W-K){1'b0}}, e.keep});
          check("emit_last", {{(W-1){1'b0}}, out_last}, {{(W-1){1'b0}}, e.last});
        end
      end

      if (in_valid && in_ready) begin
        pend_d.push_back(in_data);
        pend_k.push_back(in_keep);
        if (in_last || pend_d.size() == 2) begin
          wide_t e;
          e.data = '0;
          e.keep = '0;
          e.last = in_last;
          for (int i = 0; i < pend_d.size(); i++) begin
            e.data[i*HW +: HW] = pend_d[i];
            e.keep[i*HK +: HK] = pend_k[i];
          end
          exp_q.push_back(e);
          pend_d.delete();
          pend_k.delete();
        end
      end
    end
  end

  // ---------------- directed cycle table ----------------
  // Inputs driven for one cycle; exp_ir is in_TREADY before the edge,
  // exp_ov/exp_ol the registered outputs after it.
  typedef struct {
    bit            v;
    bit            l;
    bit            r;
    logic [HK-1:0] keep;
    bit            exp_ir;
    bit            exp_ov;
    bit            exp_ol;
    bit            chk_keep;
    logic [K-1:0]  exp_keep;
  } vec_t;

  function automatic vec_t mk(bit v, bit l, bit r, logic [HK-1:0] keep,
                              bit ir, bit ov, bit ol, bit ck, logic [K-1:0] ek);
    vec_t t;
    t.v = v; t.l = l; t.r = r; t.keep = keep;
    t.exp_ir = ir; t.exp_ov = ov; t.exp_ol = ol;
    t.chk_keep = ck; t.exp_keep = ek;
    return t;
  endfunction

  task automatic drive(input bit v, input bit l, input bit r, input logic [HK-1:0] keep);
    @(negedge clk);
    in_valid  = v;
    in_last   = l;
    in_keep   = keep;
    in_data   = rnd_half();
    out_ready = r;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, '0);
  endtask

  vec_t tbl[$];
  localparam logic [HK-1:0] KF = '1;
  localparam logic [K-1:0]  KW = '1;

  initial begin
    int acc;
    int cyc;
    logic [HW-1:0] e0;
    logic [HW-1:0] e1;

    rst_n = 1'b1; in_valid = 0; in_last = 0; in_keep = '0; in_data = '0; out_ready = 0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", {{(W-1){1'b0}}, in_ready}, '0);
    check("rst_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    check("rst_out_last", {{(W-1){1'b0}}, out_last}, '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_keep", {{(W-K){1'b0}}, out_keep}, '0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 4-beat packet
    tbl.push_back(mk(1,0,1,KF, 1,0,0, 0,'0));
    tbl.push_back(mk(1,0,1,KF, 1,1,0, 1,KW));
    tbl.push_back(mk(1,0,1,KF, 1,0,0, 0,'0));
    tbl.push_back(mk(1,1,1,KF, 1,1,1, 1,KW));
    tbl.push_back(mk(0,0,1,KF, 1,0,0, 0,'0));
    // back-to-back single-beat packets
    tbl.push_back(mk(1,1,1,KF, 1,1,1, 1,{{HK{1'b0}},KF}));
    tbl.push_back(mk(1,1,1,KF, 1,1,1, 1,{{HK{1'b0}},KF}));
    tbl.push_back(mk(0,0,1,KF, 1,0,0, 0,'0));
    // 8-beat stream with a 5-cycle stall after the first wide beat
    tbl.push_back(mk(1,0,0,KF, 1,0,0, 0,'0));
    tbl.push_back(mk(1,0,0,KF, 1,1,0, 0,'0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1,0,0,KF, 0,1,0, 0,'0));
    tbl.push_back(mk(1,0,1,KF, 1,0,0, 0,'0));
    tbl.push_back(mk(1,0,1,KF, 1,1,0, 0,'0));
    tbl.push_back(mk(1,0,1,KF, 1,0,0, 0,'0));
    tbl.push_back(mk(1,0,1,KF, 1,1,0, 0,'0));
    tbl.push_back(mk(1,0,1,KF, 1,0,0, 0,'0));
    tbl.push_back(mk(1,1,1,KF, 1,1,1, 1,KW));
    tbl.push_back(mk(0,0,1,KF, 1,0,0, 0,'0));
    // 3-beat packet, sparse keep on the tail
    tbl.push_back(mk(1,0,1,KF, 1,0,0, 0,'0));
    tbl.push_back(mk(1,0,1,KF, 1,1,0, 1,KW));
    tbl.push_back(mk(1,1,1,32'h0000FFFF, 1,1,1, 1,64'h0000_0000_0000_FFFF));
    tbl.push_back(mk(0,0,1,KF, 1,0,0, 0,'0));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].keep);
      check($sformatf("tbl%0d_in_ready", i), {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, tbl[i].exp_ir});
      @(posedge clk); #1;
      check($sformatf("tbl%0d_out_valid", i), {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, tbl[i].exp_ov});
      if (tbl[i].exp_ov)
        check($sformatf("tbl%0d_out_last", i), {{(W-1){1'b0}}, out_last}, {{(W-1){1'b0}}, tbl[i].exp_ol});
      if (tbl[i].chk_keep)
        check($sformatf("tbl%0d_out_keep", i), {{(W-K){1'b0}}, out_keep}, {{(W-K){1'b0}}, tbl[i].exp_keep});
    end

    // Throughput: both handshakes held high, 16 beats in 16 cycles.
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i == 15, 1'b1, KF);
      if (in_ready) acc++;
    end
    check("throughput", acc, 16);
    idle_cycles(2);

    // Random stream: 64 accepted beats, 50% valid and ready.
    acc = 0;
    cyc = 0;
    while (acc < 64 && cyc < 2000) begin
      drive($urandom_range(0, 1), (acc == 63) || ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
            {$urandom, $urandom} & KF);
      if (in_valid && in_ready) acc++;
      cyc++;
    end
    check("random_accepted", acc, 64);
    cyc = 0;
    drive(1'b0, 1'b0, 1'b1, '0);
    while ((exp_q.size() != 0 || out_valid) && cyc < 20) begin
      drive(1'b0, 1'b0, 1'b1, '0);
      cyc++;
    end
    check("random_drained", exp_q.size(), 0);

    // Async reset while a low half is held.
    drive(1'b1, 1'b0, 1'b1, KF);
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    check("arst_in_ready", {{(W-1){1'b0}}, in_ready}, '0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_release_ready", {{(W-1){1'b0}}, in_ready}, 1);
    drive(1'b1, 1'b0, 1'b1, KF);
    e0 = in_data;
    drive(1'b1, 1'b1, 1'b1, KF);
    e1 = in_data;
    @(posedge clk); #1;
    check("arst_new_valid", {{(W-1){1'b0}}, out_valid}, 1);
    check("arst_new_data", out_data, {e1, e0});
    idle_cycles(3);
    check("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_wtow2.md
Name: axis_wtow2

Overview:
- AXI4-Stream width up-converter: packs pairs of C_WIDTH_TDATA/2-bit input beats into one C_WIDTH_TDATA-bit output beat.
- It is the receive-side counterpart of the 512->256 down-converter in the line datapath. It restores the 512-bit bus after a narrow 256-bit segment.
- Sustains one narrow beat per cycle when the output is always ready.
- Preserves packet boundaries; a packet never shares an output beat with another packet.

Parameters:
- C_WIDTH_TDATA, 512, output TDATA width; input width is C_WIDTH_TDATA/2; must be even and a multiple of 16.
- C_WIDTH_TKEEP, C_WIDTH_TDATA/8, output TKEEP width; input width is C_WIDTH_TKEEP/2.

Ports:
- clk_line  in  1  line clock; all logic on rising edge.
- clk_line_rst_n  in  1  reset, asynchronous assert, active-low.
- in_TVALID  in  1  narrow input beat valid.
- in_TREADY  out  1  narrow input ready.
- in_TDATA  in  C_WIDTH_TDATA/2  narrow data.
- in_TKEEP  in  C_WIDTH_TKEEP/2  narrow byte enables.
- in_TLAST  in  1  last narrow beat of packet.
- out_TVALID  out  1  wide beat valid (registered).
- out_TREADY  in  1  wide beat ready.
- out_TDATA  out  C_WIDTH_TDATA  wide data (registered).
- out_TKEEP  out  C_WIDTH_TKEEP  wide byte enables (registered).
- out_TLAST  out  1  last wide beat of packet (registered).

Behaviour:
- Reset (clk_line_rst_n=0, async) forces the following, and the block stays in S_LOW until one cycle after release:
  - state=S_LOW; out_TVALID=0, out_TLAST=0, out_TDATA=0, out_TKEEP=0.
  - Low-half holding register and its keep cleared.
  - in_TREADY=0 while reset is asserted.
- Reset mid-packet discards any partially assembled beat and any unsent wide beat. No recovery of partial data.
- Lane order: the first narrow beat of a pair goes to out_TDATA[W/2-1:0] and out_TKEEP[K/2-1:0]; the second goes to the upper halves. W=C_WIDTH_TDATA, K=C_WIDTH_TKEEP.
- Accept condition: in_TVALID && in_TREADY. Emit condition: out_TVALID && out_TREADY.
- in_TREADY = reset deasserted && (state!=S_FULL || out_TREADY). This is combinational from state and out_TREADY, with no path from in_TVALID.
- States:
  - S_LOW: no low half held, no wide beat pending.
    - Accept with in_TLAST=0: capture into the low holding register; go to S_HIGH.
    - Accept with in_TLAST=1: load output with the low half = in, upper TDATA=0, upper TKEEP=0, out_TLAST=1, out_TVALID=1; go to S_FULL.
  - S_HIGH: low half held.
    - Accept: load output {in_TDATA, held_low}, {in_TKEEP, held_keep}, out_TLAST=in_TLAST, out_TVALID=1; go to S_FULL.
    - No accept: hold.
  - S_FULL: wide beat on output, held stable while out_TREADY=0.
    - Emit with no accept: out_TVALID=0; go to S_LOW.
    - Emit plus simultaneous accept: process the new beat exactly as in S_LOW in the same cycle.
      - in_TLAST=0: capture low; out_TVALID=0; go to S_HIGH.
      - in_TLAST=1: reload output with a half-beat; stay in S_FULL, out_TVALID stays 1.
- Latency: out_TVALID rises on the clock edge that accepts the completing narrow beat; it is visible in the following cycle.
- TKEEP is passed through unmodified. Sparse or zero narrow TKEEP is not checked or altered.
- in_TVALID with TLAST arriving in S_HIGH completes the pair normally, with out_TLAST=1.
- Output register never changes while out_TVALID=1 && out_TREADY=0.

Test Plan:
- Single 4-beat packet (D0..D3, keep all-ones, TLAST on D3), out_TREADY=1:
  - Expected: 2 wide beats, {D1,D0} TLAST=0 and {D3,D2} TLAST=1, keep all-ones. First out_TVALID one cycle after D1 is accepted.
- 3-beat packet D0..D2, D2 keep=0x0000FFFF:
  - Expected: 2nd wide beat has TDATA upper half =0, TKEEP=0x000000000000FFFF, TLAST=1.
- Back-to-back 1-beat packets A then B, TLAST=1 each, out_TREADY=1:
  - Expected: two wide beats, each a half-beat with upper keep 0. in_TREADY stays 1 throughout, with no merge of A and B.
- Backpressure: 8-beat stream with out_TREADY=0 for 5 cycles after the first wide beat forms:
  - in_TREADY=0 while S_FULL and not ready.
  - out_* stable across the stall.
  - All 4 wide beats delivered in order, none dropped or duplicated.
- Continuous 64-beat stream with random in_TVALID and out_TREADY (50%):
  - The scoreboard reconstructs the byte stream exactly.
  - With both held at 1, throughput is 1 narrow beat/cycle.
- Async reset asserted while in S_HIGH holding D0:
  - out_TVALID drops immediately.
  - After release, a new packet E0,E1 (TLAST) yields {E1,E0} with no trace of D0.
